// File: rtl/menu_countdown_ctrl_pkg.sv
// Shared definitions for the menu/countdown sequencer and the screen renderers.
package menu_countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_START     = 2'd2,
    ST_RUNNING   = 2'd3
  } state_t;

  localparam logic [2:0] COUNTDOWN_TOP = 3'd7;

  // Player slot indices into the ready-flag vector.
  localparam int unsigned RED    = 0;
  localparam int unsigned BLUE   = 1;
  localparam int unsigned GREEN  = 2;
  localparam int unsigned YELLOW = 3;

  // Number of set bits among the four player flags.
  function automatic logic [2:0] ready_count(input logic [3:0] flags);
    ready_count = {2'b00, flags[0]} + {2'b00, flags[1]}
                + {2'b00, flags[2]} + {2'b00, flags[3]};
  endfunction

endpackage

// File: rtl/menu_countdown_ctrl_step_prescaler.sv
// Divides clk down to a one-cycle step pulse every STEP_CYCLES cycles while run is high.
module step_prescaler #(
  parameter int unsigned STEP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic step
);

  localparam int unsigned W = $clog2(STEP_CYCLES);
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] count;

  // Count 0..STEP_CYCLES-1 while running, wrapping on the step.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Step fires on the last count of each period.
  always_comb begin
    step = run && (count == LAST);
  end

endmodule

// File: rtl/menu_countdown_ctrl.sv
// Menu sequencer: latches player joins, runs the 7..0 ring countdown, pulses
// game_start, and returns to the menu when the race reports game_over.
module menu_countdown_ctrl
  import menu_countdown_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned MIN_PLAYERS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_red,
  input  logic       btn_blue,
  input  logic       btn_green,
  input  logic       btn_yellow,
  input  logic       game_over,
  output logic       red_ready_to_play,
  output logic       blue_ready_to_play,
  output logic       green_ready_to_play,
  output logic       yellow_ready_to_play,
  output logic [2:0] countdown,
  output logic       menu_active,
  output logic       game_start,
  output logic       in_game
);

  state_t     state;
  state_t     state_next;
  logic [3:0] btn;
  logic [3:0] btn_prev;
  logic [3:0] joins;
  logic [3:0] ready;
  logic [3:0] ready_with_joins;
  logic       enough_players;
  logic [2:0] countdown_q;
  logic       in_game_q;
  logic       step;

  // Gather the buttons into a vector indexed by player slot.
  always_comb begin
    btn         = '0;
    btn[RED]    = btn_red;
    btn[BLUE]   = btn_blue;
    btn[GREEN]  = btn_green;
    btn[YELLOW] = btn_yellow;
  end

  // Previous button levels; reset high so a button held through reset is not a join.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= '1;
    end else begin
      btn_prev <= btn;
    end
  end

  // Join edges and the ready count including this cycle's joins.
  always_comb begin
    joins            = btn & ~btn_prev;
    ready_with_joins = ready | joins;
    enough_players   = ready_count(ready_with_joins) >= 3'(MIN_PLAYERS);
  end

  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(state != ST_COUNTDOWN),
    .run  (state == ST_COUNTDOWN),
    .step (step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (enough_players) state_next = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (step && (countdown_q <= 3'd1)) state_next = ST_START;
      end
      ST_START: begin
        state_next = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (game_over) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered flags, countdown value and in_game.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready       <= '0;
      countdown_q <= '0;
      in_game_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ready <= ready_with_joins;
          if (enough_players) countdown_q <= COUNTDOWN_TOP;
        end
        ST_COUNTDOWN: begin
          ready <= ready_with_joins;
          if (step) begin
            countdown_q <= (countdown_q > 3'd1) ? countdown_q - 3'd1 : '0;
          end
        end
        ST_START: begin
          countdown_q <= '0;
        end
        ST_RUNNING: begin
          if (game_over) begin
            ready       <= '0;
            countdown_q <= '0;
          end
        end
        default: begin
          ready       <= '0;
          countdown_q <= '0;
        end
      endcase
      in_game_q <= (state_next == ST_RUNNING);
    end
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    menu_active          = (state == ST_IDLE) || (state == ST_COUNTDOWN);
    game_start           = (state == ST_START);
    in_game              = in_game_q;
    countdown            = countdown_q;
    red_ready_to_play    = ready[RED];
    blue_ready_to_play   = ready[BLUE];
    green_ready_to_play  = ready[GREEN];
    yellow_ready_to_play = ready[YELLOW];
  end

endmodule
